snn_result_classifier: RTL and testbench
========================================

Name: snn_result_classifier

Overview:
- Downstream stage of the SNN core. It consumes the per-output spike counts the core writes into its output-spike-count RAM after a run.
- After a start pulse it scans the RAM through a read port with 1-cycle latency and computes the winning output (argmax), runner-up count, total spikes and tie / no-spike flags.
- It presents the results as registers with a valid pulse and a sticky interrupt for the AXI config block.

Parameters:
- NUM_OUTPUTS, 10, number of output neurons scanned; legal range 1..2^ADDR_BITS.
- ADDR_BITS, 4, count RAM address width.
- COUNT_WIDTH, 32, width of each spike count and of all count results.

Ports:
- S_AXI_ACLK  in  1  single clock, rising edge.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- start  in  1  1-cycle pulse; begin scan; sampled only in IDLE.
- clear  in  1  synchronous abort: returns to IDLE and clears results, valid, irq.
- irq_clr  in  1  clears irq.
- mem_rd_en  out  1  read strobe to count RAM.
- mem_addr  out  ADDR_BITS  read address.
- mem_dout  in  COUNT_WIDTH  RAM read data, valid the cycle after mem_rd_en.
- busy  out  1  high in SCAN and DRAIN.
- valid  out  1  1-cycle pulse when results update.
- winner_idx  out  ADDR_BITS  index of max count.
- winner_count  out  COUNT_WIDTH  max count.
- second_count  out  COUNT_WIDTH  largest count among the other indices.
- total_count  out  COUNT_WIDTH  sum of counts, saturating.
- tie  out  1  another index holds a count equal to winner_count.
- no_spikes  out  1  all counts zero.
- irq  out  1  sticky; set with valid.

Behaviour:
- Reset (async, ARESETN=0): state IDLE. All outputs are 0: mem_rd_en, mem_addr, busy, valid, winner_idx, winner_count, second_count, total_count, tie, no_spikes, irq. Internal accumulators are cleared.
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - When start=1, go to SCAN next cycle.
  - Reset accumulators to max=0, second=0, sum=0, idx=0, tie=0, rd_idx=0.
- SCAN:
  - Registered mem_rd_en=1 with mem_addr=rd_idx; rd_idx increments each cycle.
  - On the cycle mem_addr=NUM_OUTPUTS-1 is issued, go to DRAIN.
  - mem_rd_en drops to 0 in DRAIN.
- Compare pipeline: a delayed copy of mem_rd_en and mem_addr qualifies mem_dout one cycle later. For each qualified sample d at index k:
  - if d > max: second=max; max=d; idx=k; tie=0.
  - else if d == max: tie=1; second=d.
  - else if d > second: second=d.
  - sum = min(sum+d, 2^COUNT_WIDTH-1); saturation is computed on a COUNT_WIDTH+1-bit add.
- Strict greater-than compare: lowest index wins ties.
- DRAIN: consumes the final sample (index NUM_OUTPUTS-1), then goes to DONE.
- DONE (one cycle):
  - Copy accumulators to the output registers; no_spikes=(max==0).
  - valid=1 for exactly this cycle; irq set to 1. Then go to IDLE.
- Outputs hold until the next DONE, clear or reset.
- Latency: start seen at edge t0 → addresses 0..N-1 in cycles t0+1..t0+N → valid high in cycle t0+N+2.
- busy is high from t0+1 through t0+N+1 and low in the valid cycle.
- start while not IDLE: ignored; no queuing.
- clear: has priority over everything, including start and DONE in the same cycle. Goes to IDLE, drops mem_rd_en immediately (next edge), zeroes results, valid and irq.
- irq_clr in the same cycle as DONE: set wins, irq=1.
- NUM_OUTPUTS=1: SCAN lasts one cycle; second_count=0; tie=0.
- All-zero counts: winner_idx=0, winner_count=0, tie=1 when NUM_OUTPUTS>1, no_spikes=1.
- mem_addr counter never exceeds NUM_OUTPUTS-1 and does not wrap.

Test Plan:
- Reset mid-SCAN: assert ARESETN=0 with N=10 at address 4 → all outputs 0 asynchronously. A later start yields a correct full scan.
- Counts {3,7,2,9,9,0,1,4,5,6}, start → valid at t0+12; winner_idx=3, winner_count=9, second_count=9, tie=1, total_count=46, irq=1; mem_addr sequence 0..9 contiguous.
- Counts {0,...,0,5 at index 9} → winner_idx=9, winner_count=5, second_count=0, tie=0, no_spikes=0, total_count=5. All zeros → winner_idx=0, no_spikes=1, tie=1.
- Counts {0xFFFFFFF0, 0x20, rest 0} → total_count=0xFFFFFFFF (saturated), winner_idx=0, second_count=0x20.
- Second start pulse during SCAN → ignored; exactly one valid pulse; busy contiguous for 11 cycles.
- clear asserted at address 5 → IDLE next cycle, mem_rd_en=0, results 0, no valid. irq_clr coincident with DONE → irq stays 1; a later lone irq_clr → irq=0.

Source files
------------

// File: rtl/snn_result_classifier.sv
// rtl/snn_result_classifier.sv - argmax / runner-up / total classifier over the SNN output spike-count RAM
//
// Purpose:
//   After a start pulse, reads NUM_OUTPUTS spike counts from the core's count RAM
//   (1-cycle read latency). It then publishes these results:
//   - the winning index (lowest index wins on equal counts)
//   - the winner count
//   - the runner-up count
//   - a saturating total
//   - tie and no-spike flags
//   It also raises a one-cycle valid pulse and a sticky irq.
//
// Ports:
//   S_AXI_ACLK     in   clock, rising edge
//   S_AXI_ARESETN  in   asynchronous active-low reset
//   start          in   begin a scan (only honoured in IDLE)
//   clear          in   synchronous abort; zeroes results, valid and irq
//   irq_clr        in   clears the sticky irq
//   mem_rd_en      out  count RAM read strobe
//   mem_addr       out  count RAM read address
//   mem_dout       in   count RAM read data, valid the cycle after mem_rd_en
//   busy           out  scan in progress (SCAN and DRAIN)
//   valid          out  one-cycle pulse when results update
//   winner_idx     out  index of the largest count
//   winner_count   out  largest count
//   second_count   out  largest count among the other indices
//   total_count    out  saturating sum of all counts
//   tie            out  another index holds the winner count
//   no_spikes      out  every count was zero
//   irq            out  sticky, set together with valid
module snn_result_classifier #(
  parameter int NUM_OUTPUTS = 10,
  parameter int ADDR_BITS   = 4,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  input  logic                   start,
  input  logic                   clear,
  input  logic                   irq_clr,
  output logic                   mem_rd_en,
  output logic [ADDR_BITS-1:0]   mem_addr,
  input  logic [COUNT_WIDTH-1:0] mem_dout,
  output logic                   busy,
  output logic                   valid,
  output logic [ADDR_BITS-1:0]   winner_idx,
  output logic [COUNT_WIDTH-1:0] winner_count,
  output logic [COUNT_WIDTH-1:0] second_count,
  output logic [COUNT_WIDTH-1:0] total_count,
  output logic                   tie,
  output logic                   no_spikes,
  output logic                   irq
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_OUTPUTS - 1);

  state_t r_state;
  state_t w_state_nxt;

  // Read issue registers.
  logic                   r_mem_rd_en;
  logic [ADDR_BITS-1:0]   r_mem_addr;

  // One-cycle delayed copy of the read strobe/address; qualifies mem_dout.
  logic                   r_smp_vld;
  logic [ADDR_BITS-1:0]   r_smp_idx;

  // Running accumulators.
  logic [COUNT_WIDTH-1:0] r_acc_max;
  logic [COUNT_WIDTH-1:0] r_acc_second;
  logic [COUNT_WIDTH-1:0] r_acc_sum;
  logic [ADDR_BITS-1:0]   r_acc_idx;
  logic                   r_acc_tie;

  // Published results.
  logic [ADDR_BITS-1:0]   r_winner_idx;
  logic [COUNT_WIDTH-1:0] r_winner_count;
  logic [COUNT_WIDTH-1:0] r_second_count;
  logic [COUNT_WIDTH-1:0] r_total_count;
  logic                   r_tie;
  logic                   r_no_spikes;
  logic                   r_irq;

  // Next accumulator values including the sample currently on mem_dout.
  logic [COUNT_WIDTH-1:0] w_max_nxt;
  logic [COUNT_WIDTH-1:0] w_second_nxt;
  logic [COUNT_WIDTH-1:0] w_sum_nxt;
  logic [ADDR_BITS-1:0]   w_idx_nxt;
  logic                   w_tie_nxt;
  logic [COUNT_WIDTH:0]   w_sum_ext;
  logic [COUNT_WIDTH-1:0] w_sum_sat;
  logic                   w_first;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    valid       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        busy = 1'b1;
        if (r_mem_addr == LAST_ADDR) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy        = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        valid       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (clear) w_state_nxt = ST_IDLE;
  end

  // ---------------------------------------------------------- compare
  assign w_sum_ext = {1'b0, r_acc_sum} + {1'b0, mem_dout};
  assign w_sum_sat = w_sum_ext[COUNT_WIDTH] ? {COUNT_WIDTH{1'b1}} : w_sum_ext[COUNT_WIDTH-1:0];
  // Index 0 seeds the accumulators so a lone zero count does not look like a tie.
  assign w_first   = (r_smp_idx == '0);

  always_comb begin
    w_max_nxt    = r_acc_max;
    w_second_nxt = r_acc_second;
    w_sum_nxt    = r_acc_sum;
    w_idx_nxt    = r_acc_idx;
    w_tie_nxt    = r_acc_tie;
    if (r_smp_vld) begin
      if (w_first) begin
        w_max_nxt    = mem_dout;
        w_second_nxt = '0;
        w_idx_nxt    = '0;
        w_tie_nxt    = 1'b0;
      end else if (mem_dout > r_acc_max) begin
        w_second_nxt = r_acc_max;
        w_max_nxt    = mem_dout;
        w_idx_nxt    = r_smp_idx;
        w_tie_nxt    = 1'b0;
      end else if (mem_dout == r_acc_max) begin
        w_tie_nxt    = 1'b1;
        w_second_nxt = mem_dout;
      end else if (mem_dout > r_acc_second) begin
        w_second_nxt = mem_dout;
      end
      w_sum_nxt = w_sum_sat;
    end
  end

  // ---------------------------------------------------------- datapath
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_mem_rd_en    <= 1'b0;
      r_mem_addr     <= '0;
      r_smp_vld      <= 1'b0;
      r_smp_idx      <= '0;
      r_acc_max      <= '0;
      r_acc_second   <= '0;
      r_acc_sum      <= '0;
      r_acc_idx      <= '0;
      r_acc_tie      <= 1'b0;
      r_winner_idx   <= '0;
      r_winner_count <= '0;
      r_second_count <= '0;
      r_total_count  <= '0;
      r_tie          <= 1'b0;
      r_no_spikes    <= 1'b0;
      r_irq          <= 1'b0;
    end else if (clear) begin
      r_mem_rd_en    <= 1'b0;
      r_mem_addr     <= '0;
      r_smp_vld      <= 1'b0;
      r_smp_idx      <= '0;
      r_acc_max      <= '0;
      r_acc_second   <= '0;
      r_acc_sum      <= '0;
      r_acc_idx      <= '0;
      r_acc_tie      <= 1'b0;
      r_winner_idx   <= '0;
      r_winner_count <= '0;
      r_second_count <= '0;
      r_total_count  <= '0;
      r_tie          <= 1'b0;
      r_no_spikes    <= 1'b0;
      r_irq          <= 1'b0;
    end else begin
      r_smp_vld <= r_mem_rd_en;
      r_smp_idx <= r_mem_addr;

      if (r_state == ST_IDLE) begin
        r_acc_max    <= '0;
        r_acc_second <= '0;
        r_acc_sum    <= '0;
        r_acc_idx    <= '0;
        r_acc_tie    <= 1'b0;
      end else begin
        r_acc_max    <= w_max_nxt;
        r_acc_second <= w_second_nxt;
        r_acc_sum    <= w_sum_nxt;
        r_acc_idx    <= w_idx_nxt;
        r_acc_tie    <= w_tie_nxt;
      end

      if (irq_clr) r_irq <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mem_rd_en <= 1'b1;
            r_mem_addr  <= '0;
          end
        end
        ST_SCAN: begin
          if (r_mem_addr == LAST_ADDR) begin
            r_mem_rd_en <= 1'b0;
            r_mem_addr  <= '0;
          end else begin
            r_mem_addr  <= r_mem_addr + 1'b1;
          end
        end
        ST_DRAIN: begin
          // Results are loaded from the next-values so they are visible
          // in the same cycle that valid is high (the DONE state).
          r_winner_idx   <= w_idx_nxt;
          r_winner_count <= w_max_nxt;
          r_second_count <= w_second_nxt;
          r_total_count  <= w_sum_nxt;
          r_tie          <= w_tie_nxt;
          r_no_spikes    <= (w_max_nxt == '0);
          r_irq          <= 1'b1;
        end
        ST_DONE: begin
          // Set wins over an irq_clr that lands in the valid cycle.
          r_irq <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_rd_en    = r_mem_rd_en;
  assign mem_addr     = r_mem_addr;
  assign winner_idx   = r_winner_idx;
  assign winner_count = r_winner_count;
  assign second_count = r_second_count;
  assign total_count  = r_total_count;
  assign tie          = r_tie;
  assign no_spikes    = r_no_spikes;
  assign irq          = r_irq;

endmodule

// File: tb/tb_snn_result_classifier.sv
// tb/tb_snn_result_classifier.sv - directed scoreboard bench for snn_result_classifier
module tb_snn_result_classifier;

  localparam int N = 10;

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] win;
    logic [31:0] sec;
    logic [31:0] tot;
    logic        tie;
    logic        nsp;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        clear;
  logic        irq_clr;
  logic        mem_rd_en;
  logic [3:0]  mem_addr;
  logic [31:0] mem_dout;
  logic        busy;
  logic        valid;
  logic [3:0]  winner_idx;
  logic [31:0] winner_count;
  logic [31:0] second_count;
  logic [31:0] total_count;
  logic        tie;
  logic        no_spikes;
  logic        irq;

  logic [31:0] ram [0:15];
  res_t        sb_q[$];
  int          addr_q[$];
  int          n_vec;
  int          n_err;
  int          n_valid;
  int          n_busy;

  snn_result_classifier #(.NUM_OUTPUTS(N), .ADDR_BITS(4), .COUNT_WIDTH(32)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .start        (start),
    .clear        (clear),
    .irq_clr      (irq_clr),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_dout     (mem_dout),
    .busy         (busy),
    .valid        (valid),
    .winner_idx   (winner_idx),
    .winner_count (winner_count),
    .second_count (second_count),
    .total_count  (total_count),
    .tie          (tie),
    .no_spikes    (no_spikes),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_dout <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: argmax with lowest index on ties, runner-up as max over the
  // other indices, saturating total computed on a wide sum.
  function automatic res_t model();
    res_t        r;
    logic [63:0] s;
    int          b;
    b = 0;
    for (int k = 1; k < N; k++) if (ram[k] > ram[b]) b = k;
    r.idx = 4'(b);
    r.win = ram[b];
    r.sec = 32'd0;
    r.tie = 1'b0;
    s     = 64'd0;
    for (int k = 0; k < N; k++) begin
      s = s + {32'd0, ram[k]};
      if (k != b) begin
        if (ram[k] > r.sec) r.sec = ram[k];
        if (ram[k] == ram[b]) r.tie = 1'b1;
      end
    end
    r.tot = (s > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
    r.nsp = (ram[b] == 32'd0);
    return r;
  endfunction

  // Output monitor: scoreboard pop on valid, address order, busy count.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) n_busy++;
      if (mem_rd_en) begin
        check("addr_expected", 64'(addr_q.size() != 0), 64'd1);
        if (addr_q.size() != 0) check("mem_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
      end
      if (valid) begin
        n_valid++;
        check("valid_expected", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          res_t e;
          e = sb_q.pop_front();
          check("winner_idx",   64'(winner_idx),   64'(e.idx));
          check("winner_count", 64'(winner_count), 64'(e.win));
          check("second_count", 64'(second_count), 64'(e.sec));
          check("total_count",  64'(total_count),  64'(e.tot));
          check("tie",          64'(tie),          64'(e.tie));
          check("no_spikes",    64'(no_spikes),    64'(e.nsp));
          check("irq_on_valid", 64'(irq),          64'd1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a();
    logic [31:0] v [0:9];
    v = '{32'd3, 32'd7, 32'd2, 32'd9, 32'd9, 32'd0, 32'd1, 32'd4, 32'd5, 32'd6};
    for (int k = 0; k < 16; k++) ram[k] = (k < N) ? v[k] : 32'd0;
  endtask

  task automatic load_zero();
    for (int k = 0; k < 16; k++) ram[k] = 32'd0;
  endtask

  // Full scan: start pulse, optional extra start at cycle `extra`,
  // optional irq_clr in the valid cycle.
  task automatic run_scan(input string tag, input int extra, input bit clr_at_valid);
    int cyc;
    int v0;
    sb_q.push_back(model());
    for (int k = 0; k < N; k++) addr_q.push_back(k);
    v0     = n_valid;
    n_busy = 0;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    cyc    = 1;
    while (!valid && cyc < 40) begin
      if (cyc == extra) start = 1'b1;
      tick();
      start = 1'b0;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(N + 2));
    check({tag, "_busy_in_valid"}, 64'(busy), 64'd0);
    if (clr_at_valid) irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check({tag, "_valid_one_cycle"}, 64'(valid), 64'd0);
    check({tag, "_irq_after"}, 64'(irq), 64'd1);
    repeat (14) tick();
    check({tag, "_valid_pulses"}, 64'(n_valid - v0), 64'd1);
    check({tag, "_busy_cycles"}, 64'(n_busy), 64'(N + 1));
    check({tag, "_addr_all_seen"}, 64'(addr_q.size()), 64'd0);
  endtask

  initial begin
    int cyc;
    int v0;
    n_vec   = 0;
    n_err   = 0;
    n_valid = 0;
    n_busy  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    clear   = 1'b0;
    irq_clr = 1'b0;
    load_zero();

    repeat (3) tick();
    check("rst_mem_rd_en",    64'(mem_rd_en),    64'd0);
    check("rst_mem_addr",     64'(mem_addr),     64'd0);
    check("rst_busy",         64'(busy),         64'd0);
    check("rst_valid",        64'(valid),        64'd0);
    check("rst_winner_idx",   64'(winner_idx),   64'd0);
    check("rst_winner_count", 64'(winner_count), 64'd0);
    check("rst_second_count", 64'(second_count), 64'd0);
    check("rst_total_count",  64'(total_count),  64'd0);
    check("rst_tie",          64'(tie),          64'd0);
    check("rst_no_spikes",    64'(no_spikes),    64'd0);
    check("rst_irq",          64'(irq),          64'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Mixed counts with a tie at the maximum.
    load_a();
    run_scan("mixed", 0, 1'b0);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check("lone_irq_clr", 64'(irq), 64'd0);

    // Single nonzero count at the last index.
    load_zero();
    ram[9] = 32'd5;
    run_scan("last_only", 0, 1'b0);

    // All zero counts.
    load_zero();
    run_scan("all_zero", 0, 1'b0);

    // Saturating total.
    load_zero();
    ram[0] = 32'hFFFF_FFF0;
    ram[1] = 32'h0000_0020;
    run_scan("saturate", 0, 1'b0);

    // Second start during SCAN is ignored.
    load_a();
    run_scan("restart", 3, 1'b0);

    // irq_clr coincident with the valid cycle: irq stays set.
    load_zero();
    ram[2] = 32'd11;
    ram[6] = 32'd4;
    run_scan("irqclr_done", 0, 1'b1);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check("irqclr_later", 64'(irq), 64'd0);

    // Clear at address 5 after a completed scan left results and irq set.
    load_a();
    run_scan("pre_clear", 0, 1'b0);
    for (int k = 0; k <= 5; k++) addr_q.push_back(k);
    v0    = n_valid;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 0;
    while (!(mem_rd_en && mem_addr == 4'd5) && cyc < 20) begin
      tick();
      cyc++;
    end
    check("clr_reach_addr5", 64'(mem_addr), 64'd5);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_mem_rd_en",    64'(mem_rd_en),    64'd0);
    check("clr_busy",         64'(busy),         64'd0);
    check("clr_winner_idx",   64'(winner_idx),   64'd0);
    check("clr_winner_count", 64'(winner_count), 64'd0);
    check("clr_second_count", 64'(second_count), 64'd0);
    check("clr_total_count",  64'(total_count),  64'd0);
    check("clr_tie",          64'(tie),          64'd0);
    check("clr_irq",          64'(irq),          64'd0);
    repeat (15) tick();
    check("clr_no_valid",     64'(n_valid - v0),   64'd0);
    check("clr_addr_seen",    64'(addr_q.size()),  64'd0);

    // Asynchronous reset in the middle of a scan, then a full scan.
    load_a();
    for (int k = 0; k <= 4; k++) addr_q.push_back(k);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 0;
    while (!(mem_rd_en && mem_addr == 4'd4) && cyc < 20) begin
      tick();
      cyc++;
    end
    check("mid_rst_reach_addr4", 64'(mem_addr), 64'd4);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_mem_rd_en",    64'(mem_rd_en),    64'd0);
    check("mid_rst_mem_addr",     64'(mem_addr),     64'd0);
    check("mid_rst_busy",         64'(busy),         64'd0);
    check("mid_rst_winner_count", 64'(winner_count), 64'd0);
    check("mid_rst_total_count",  64'(total_count),  64'd0);
    check("mid_rst_irq",          64'(irq),          64'd0);
    check("mid_rst_addr_seen",    64'(addr_q.size()), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    load_zero();
    ram[0] = 32'hFFFF_FFF0;
    ram[1] = 32'h0000_0020;
    ram[7] = 32'h0000_0100;
    run_scan("after_rst", 0, 1'b0);

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
